axil_app_arb: RTL and testbench

AXIL_APP_ARB -- requirements
Module: axil_app_arb

---
 rtl/axil_arb_pkg.sv | 22 ++
 rtl/rr_arbiter.sv | 37 +++
 rtl/axil_app_arb.sv | 192 +++++++++++++++++++
 tb/tb_axil_app_arb.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axil_arb_pkg.sv
// ============================================================================
// axil_arb_pkg : shared types and widths for the AXI-Lite application arbiter
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package axil_arb_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int TO_W   = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_e;

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
// rr_arbiter : combinational round-robin pick, searching upward from last+1
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module rr_arbiter
  import axil_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_grant,
  output logic [IDX_W-1:0]   grant,
  output logic               any_req
);

  int idx;

  // Walk from the farthest candidate to the nearest so the nearest requester
  // after last_grant is the one left standing.
  always_comb begin
    idx     = 0;
    grant   = '0;
    any_req = |req;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = (int'(last_grant) + k) % NUM_REQ;
      if (req[idx]) begin
        grant = IDX_W'(idx);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/axil_app_arb.sv
// ============================================================================
// axil_app_arb : shares one AXI-Lite master application port among NUM_REQ
//                requesters, one transaction at a time, with a done timeout
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module axil_app_arb
  import axil_arb_pkg::*;
#(
  parameter int NUM_REQ     = 2,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                      aclk,
  input  logic                      areset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_done,
  output logic                      req_err,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic [ADDR_W-1:0]         app_waddr,
  output logic [DATA_W-1:0]         app_wdata,
  output logic [ADDR_W-1:0]         app_raddr,
  output logic                      app_wen,
  output logic                      app_ren,
  input  logic                      app_wdone,
  input  logic                      app_rdone,
  input  logic [DATA_W-1:0]         app_rdata
);

  localparam int              IDX_W   = $clog2(NUM_REQ);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

  arb_state_e          state_q, state_d;
  logic [IDX_W-1:0]    grant_q, grant_d;
  logic [IDX_W-1:0]    last_g_q, last_g_d;
  logic                is_wr_q, is_wr_d;
  logic [TO_W-1:0]     tmo_q, tmo_d;
  logic [ADDR_W-1:0]   app_waddr_q, app_waddr_d;
  logic [DATA_W-1:0]   app_wdata_q, app_wdata_d;
  logic [ADDR_W-1:0]   app_raddr_q, app_raddr_d;
  logic                app_wen_q, app_wen_d;
  logic                app_ren_q, app_ren_d;
  logic [NUM_REQ-1:0]  req_done_q, req_done_d;
  logic                req_err_q, req_err_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;

  logic [IDX_W-1:0]    arb_grant;
  logic                arb_any;
  logic                sel_we;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;
  logic [NUM_REQ-1:0]  grant_onehot;
  logic                done_match;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_arbiter (
    .req        (req_valid),
    .last_grant (last_g_q),
    .grant      (arb_grant),
    .any_req    (arb_any)
  );

  // Fields of the currently granted requester.
  always_comb begin
    sel_we       = 1'b0;
    sel_addr     = '0;
    sel_wdata    = '0;
    grant_onehot = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q == IDX_W'(i)) begin
        sel_we          = req_we[i];
        sel_addr        = req_addr[ADDR_W*i +: ADDR_W];
        sel_wdata       = req_wdata[DATA_W*i +: DATA_W];
        grant_onehot[i] = 1'b1;
      end
    end
  end

  assign done_match = is_wr_q ? app_wdone : app_rdone;

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    last_g_d    = last_g_q;
    is_wr_d     = is_wr_q;
    tmo_d       = tmo_q;
    app_waddr_d = app_waddr_q;
    app_wdata_d = app_wdata_q;
    app_raddr_d = app_raddr_q;
    app_wen_d   = 1'b0;
    app_ren_d   = 1'b0;
    req_done_d  = '0;
    req_err_d   = 1'b0;
    rsp_rdata_d = '0;

    case (state_q)
      ST_IDLE: begin
        if (arb_any) begin
          grant_d = arb_grant;
          state_d = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        is_wr_d = sel_we;
        tmo_d   = '0;
        if (sel_we) begin
          app_waddr_d = sel_addr;
          app_wdata_d = sel_wdata;
          app_wen_d   = 1'b1;
        end else begin
          app_raddr_d = sel_addr;
          app_ren_d   = 1'b1;
        end
        state_d = ST_WAIT;
      end

      ST_WAIT: begin
        // A done landing on the terminal count wins over the timeout.
        if (done_match) begin
          req_done_d  = grant_onehot;
          rsp_rdata_d = is_wr_q ? '0 : app_rdata;
          state_d     = ST_RESP;
        end else if (tmo_q == TO_LAST) begin
          req_done_d = grant_onehot;
          req_err_d  = 1'b1;
          state_d    = ST_RESP;
        end else begin
          tmo_d = tmo_q + TO_W'(1);
        end
      end

      ST_RESP: begin
        last_g_d = grant_q;
        state_d  = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q     <= ST_IDLE;
      grant_q     <= '0;
      last_g_q    <= IDX_W'(NUM_REQ - 1);
      is_wr_q     <= 1'b0;
      tmo_q       <= '0;
      app_waddr_q <= '0;
      app_wdata_q <= '0;
      app_raddr_q <= '0;
      app_wen_q   <= 1'b0;
      app_ren_q   <= 1'b0;
      req_done_q  <= '0;
      req_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      last_g_q    <= last_g_d;
      is_wr_q     <= is_wr_d;
      tmo_q       <= tmo_d;
      app_waddr_q <= app_waddr_d;
      app_wdata_q <= app_wdata_d;
      app_raddr_q <= app_raddr_d;
      app_wen_q   <= app_wen_d;
      app_ren_q   <= app_ren_d;
      req_done_q  <= req_done_d;
      req_err_q   <= req_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign req_done  = req_done_q;
  assign req_err   = req_err_q;
  assign rsp_rdata = rsp_rdata_q;
  assign app_waddr = app_waddr_q;
  assign app_wdata = app_wdata_q;
  assign app_raddr = app_raddr_q;
  assign app_wen   = app_wen_q;
  assign app_ren   = app_ren_q;

endmodule

`default_nettype wire

// File: tb/tb_axil_app_arb.sv
// ============================================================================
// tb_axil_app_arb : directed stimulus with a queue scoreboard and monitor
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_axil_app_arb;

  localparam int NUM_REQ     = 2;
  localparam int TIMEOUT_CYC = 8;
  localparam int MST_LAT     = 1;

  logic        aclk      = 1'b0;
  logic        areset    = 1'b1;
  logic [1:0]  req_valid = '0;
  logic [1:0]  req_we    = '0;
  logic [63:0] req_addr  = '0;
  logic [63:0] req_wdata = '0;
  logic [1:0]  req_done;
  logic        req_err;
  logic [31:0] rsp_rdata;
  logic [31:0] app_waddr, app_wdata, app_raddr;
  logic        app_wen, app_ren;
  logic        app_wdone = 1'b0;
  logic        app_rdone = 1'b0;
  logic [31:0] app_rdata = '0;

  always #5 aclk = ~aclk;

  axil_app_arb #(
    .NUM_REQ     (NUM_REQ),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .aclk      (aclk),
    .areset    (areset),
    .req_valid (req_valid),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_done  (req_done),
    .req_err   (req_err),
    .rsp_rdata (rsp_rdata),
    .app_waddr (app_waddr),
    .app_wdata (app_wdata),
    .app_raddr (app_raddr),
    .app_wen   (app_wen),
    .app_ren   (app_ren),
    .app_wdone (app_wdone),
    .app_rdone (app_rdone),
    .app_rdata (app_rdata)
  );

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } app_exp_t;

  typedef struct {
    int          idx;
    bit          we;
    bit          err;
    logic [31:0] rdata;
    int          lat;
  } rsp_exp_t;

  app_exp_t app_q[$];
  rsp_exp_t rsp_q[$];

  int n_checks = 0;
  int n_errors = 0;
  bit tb_end   = 1'b0;
  bit done_allowed = 1'b1;

  // Bench-side master and requester behaviour, advanced once per cycle.
  bit          mst_auto = 1'b0;
  bit          mst_busy = 1'b0;
  bit          mst_is_w = 1'b0;
  int          mst_cnt  = 0;
  int          rearm_cnt[2];
  bit          rearm_pend[2];

  task automatic tick();
    @(posedge aclk);
    #1;
    if (mst_auto) begin
      app_wdone = 1'b0;
      app_rdone = 1'b0;
      if (app_wen || app_ren) begin
        mst_busy = 1'b1;
        mst_is_w = app_wen;
        mst_cnt  = MST_LAT;
      end else if (mst_busy) begin
        if (mst_cnt == 0) begin
          app_wdone = mst_is_w;
          app_rdone = !mst_is_w;
          mst_busy  = 1'b0;
        end else begin
          mst_cnt--;
        end
      end
    end
    for (int i = 0; i < 2; i++) begin
      if (req_done[i]) begin
        req_valid[i] = 1'b0;
        if (rearm_cnt[i] > 0) begin
          rearm_cnt[i]--;
          rearm_pend[i] = 1'b1;
        end
      end else if (rearm_pend[i]) begin
        req_valid[i]  = 1'b1;
        rearm_pend[i] = 1'b0;
      end
    end
  endtask

  task automatic push_app(input bit we, input logic [31:0] addr, input logic [31:0] wdata);
    app_exp_t e;
    e.we = we; e.addr = addr; e.wdata = wdata;
    app_q.push_back(e);
  endtask

  task automatic push_rsp(input int idx, input bit we, input bit err, input logic [31:0] rdata, input int lat);
    rsp_exp_t e;
    e.idx = idx; e.we = we; e.err = err; e.rdata = rdata; e.lat = lat;
    rsp_q.push_back(e);
  endtask

  task automatic set_req(input int i, input bit we, input logic [31:0] addr, input logic [31:0] wdata);
    req_we[i]             = we;
    req_addr[32*i +: 32]  = addr;
    req_wdata[32*i +: 32] = wdata;
  endtask

  // Stimulus
  initial begin
    rearm_cnt[0] = 0; rearm_cnt[1] = 0;
    rearm_pend[0] = 1'b0; rearm_pend[1] = 1'b0;
    repeat (3) tick();
    areset = 1'b0;
    tick();

    // Single write from requester 0
    mst_auto = 1'b1;
    set_req(0, 1'b1, 32'hAAAA_BBBB, 32'h5AA5_A55A);
    push_app(1'b1, 32'hAAAA_BBBB, 32'h5AA5_A55A);
    push_rsp(0, 1'b1, 1'b0, 32'h0, -1);
    app_rdata = 32'hCAFE_0001;
    req_valid[0] = 1'b1;
    repeat (12) tick();

    // Single read from requester 1
    app_rdata = 32'hDEAD_BEEF;
    set_req(1, 1'b0, 32'h0000_0010, 32'h0);
    push_app(1'b0, 32'h0000_0010, 32'h0);
    push_rsp(1, 1'b0, 1'b0, 32'hDEAD_BEEF, -1);
    req_valid[1] = 1'b1;
    repeat (12) tick();

    // Contention from reset: expected grant order 0,1,0,1
    areset = 1'b1;
    app_rdata = 32'h0000_0022;
    set_req(0, 1'b1, 32'h0000_0100, 32'h0000_0011);
    set_req(1, 1'b0, 32'h0000_0200, 32'h0);
    req_valid = 2'b11;
    rearm_cnt[0] = 1; rearm_cnt[1] = 1;
    repeat (2) tick();
    areset = 1'b0;
    for (int n = 0; n < 2; n++) begin
      push_app(1'b1, 32'h0000_0100, 32'h0000_0011);
      push_rsp(0, 1'b1, 1'b0, 32'h0, -1);
      push_app(1'b0, 32'h0000_0200, 32'h0);
      push_rsp(1, 1'b0, 1'b0, 32'h0000_0022, -1);
    end
    repeat (50) tick();

    // Timeout: silent master, read from requester 0
    mst_auto = 1'b0;
    app_rdata = 32'h7777_7777;
    set_req(0, 1'b0, 32'h0000_0030, 32'h0);
    push_app(1'b0, 32'h0000_0030, 32'h0);
    push_rsp(0, 1'b0, 1'b1, 32'h0, 8);
    req_valid[0] = 1'b1;
    repeat (20) tick();

    // Reset while waiting; a stale done afterwards must produce nothing
    done_allowed = 1'b0;
    set_req(1, 1'b1, 32'h0000_0040, 32'h0000_0044);
    push_app(1'b1, 32'h0000_0040, 32'h0000_0044);
    req_valid[1] = 1'b1;
    repeat (4) tick();
    areset = 1'b1;
    req_valid = 2'b00;
    tick();
    areset = 1'b0;
    app_wdone = 1'b1;
    tick();
    app_wdone = 1'b0;
    repeat (4) tick();
    done_allowed = 1'b1;
    mst_auto = 1'b1;
    mst_busy = 1'b0;
    app_rdata = 32'h6666_0000;
    set_req(0, 1'b1, 32'h0000_0050, 32'h0000_0055);
    set_req(1, 1'b0, 32'h0000_0060, 32'h0);
    push_app(1'b1, 32'h0000_0050, 32'h0000_0055);
    push_rsp(0, 1'b1, 1'b0, 32'h0, -1);
    push_app(1'b0, 32'h0000_0060, 32'h0);
    push_rsp(1, 1'b0, 1'b0, 32'h6666_0000, -1);
    req_valid = 2'b11;
    repeat (30) tick();

    // Wrong-type done during a write is ignored
    mst_auto = 1'b0;
    done_allowed = 1'b0;
    set_req(0, 1'b1, 32'h0000_0070, 32'h0000_0077);
    push_app(1'b1, 32'h0000_0070, 32'h0000_0077);
    push_rsp(0, 1'b1, 1'b0, 32'h0, -1);
    req_valid[0] = 1'b1;
    tick();                 // ISSUE
    tick();                 // WAIT cycle 0
    tick();                 // WAIT cycle 1
    app_rdone = 1'b1;
    tick();
    app_rdone = 1'b0;
    tick();                 // WAIT cycle 3
    app_wdone = 1'b1;
    done_allowed = 1'b1;
    tick();
    app_wdone = 1'b0;
    repeat (4) tick();

    // Done on the timeout terminal count counts as success
    app_rdata = 32'h1234_5678;
    set_req(1, 1'b0, 32'h0000_0080, 32'h0);
    push_app(1'b0, 32'h0000_0080, 32'h0);
    push_rsp(1, 1'b0, 1'b0, 32'h1234_5678, -1);
    req_valid[1] = 1'b1;
    tick();                 // ISSUE
    tick();                 // WAIT cycle 0
    repeat (TIMEOUT_CYC - 1) tick();
    app_rdone = 1'b1;
    tick();
    app_rdone = 1'b0;
    repeat (4) tick();

    tb_end = 1'b1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor / scoreboard
  initial begin
    int       cyc;
    int       last_wd;
    int       last_rd;
    int       last_issue;
    bit       rst_prev;
    app_exp_t ea;
    rsp_exp_t er;
    cyc = 0; last_wd = -100; last_rd = -100; last_issue = -100; rst_prev = 1'b0;
    forever begin
      @(negedge aclk);
      cyc++;
      if (tb_end) begin
        chk("app_queue_drained", 32'(app_q.size()), 32'd0);
        chk("rsp_queue_drained", 32'(rsp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
      end
      if (cyc > 5000) begin
        n_checks++; n_errors++;
        $display("FAIL watchdog: stimulus did not finish within 5000 cycles");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
      end
      if (rst_prev) begin
        chk("reset_req_done", 32'(req_done), 32'd0);
        chk("reset_app_pulses", {30'd0, app_wen, app_ren}, 32'd0);
        chk("reset_err", {31'd0, req_err}, 32'd0);
        chk("reset_data_outs", app_waddr | app_wdata | app_raddr | rsp_rdata, 32'd0);
      end
      rst_prev = areset;

      if (app_wen && app_ren) chk("app_pulse_overlap", 32'd1, 32'd0);
      if (app_wen || app_ren) begin
        last_issue = cyc;
        if (app_q.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL unexpected_app_pulse: got wen=%0b ren=%0b with nothing expected", app_wen, app_ren);
        end else begin
          ea = app_q.pop_front();
          chk("app_type_wen", {31'd0, app_wen}, {31'd0, ea.we});
          chk("app_addr", ea.we ? app_waddr : app_raddr, ea.addr);
          if (ea.we) chk("app_wdata", app_wdata, ea.wdata);
        end
      end

      if (req_done != 2'b00) begin
        chk("done_permitted", {31'd0, done_allowed}, 32'd1);
        if (rsp_q.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL unexpected_req_done: got 0x%0h with nothing expected", req_done);
        end else begin
          er = rsp_q.pop_front();
          chk("req_done_grant", 32'(req_done), 32'd1 << er.idx);
          chk("req_err", {31'd0, req_err}, {31'd0, er.err});
          chk("rsp_rdata", rsp_rdata, er.rdata);
          if (er.lat >= 0) chk("timeout_latency", 32'(cyc - last_issue), 32'(er.lat));
          if (!er.err) chk("done_latency", 32'(cyc - (er.we ? last_wd : last_rd)), 32'd1);
        end
      end
      if (app_wdone) last_wd = cyc;
      if (app_rdone) last_rd = cyc;
    end
  end

endmodule

`default_nettype wire
